// File: rtl/axi_burst_splitter_if.sv
// rtl/axi_burst_splitter_if.sv - request and burst-command bundle for axi_burst_splitter
// The slave modport is the splitter itself; master is whoever issues requests and takes bursts.
interface axi_burst_splitter_if #(
  parameter int AXI_ADDR_W     = 32,
  parameter int AXI_DATA_W     = 32,
  parameter int TRANSFER_LEN_W = 20
);
  localparam int LOG_B = $clog2(AXI_DATA_W / 8);
  localparam int OFF_W = (LOG_B > 0) ? LOG_B : 1;

  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [AXI_ADDR_W-1:0]     cmd_addr_i;
  logic [TRANSFER_LEN_W-1:0] cmd_len_i;
  logic                      burst_valid_o;
  logic                      burst_ready_i;
  logic [AXI_ADDR_W-1:0]     burst_addr_o;
  logic [7:0]                burst_len_o;
  logic [2:0]                burst_size_o;
  logic [OFF_W-1:0]          burst_offset_o;
  logic [12:0]               burst_bytes_o;
  logic                      burst_first_o;
  logic                      burst_last_o;
  logic                      busy_o;
  logic                      done_o;

  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, burst_ready_i,
    output cmd_ready_o, burst_valid_o, burst_addr_o, burst_len_o, burst_size_o,
           burst_offset_o, burst_bytes_o, burst_first_o, burst_last_o, busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, burst_ready_i,
    input  cmd_ready_o, burst_valid_o, burst_addr_o, burst_len_o, burst_size_o,
           burst_offset_o, burst_bytes_o, burst_first_o, burst_last_o, busy_o, done_o
  );
endinterface

// File: rtl/axi_burst_splitter.sv
// rtl/axi_burst_splitter.sv - splits a byte-granular transfer into AXI bursts
// Bursts stop at 4 KB boundaries and at MAX_BEATS beats; fields derive from the live address/remaining regs.
module axi_burst_splitter #(
  parameter int AXI_ADDR_W     = 32,
  parameter int AXI_DATA_W     = 32,
  parameter int TRANSFER_LEN_W = 20,
  parameter int MAX_BEATS      = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_burst_splitter_if.slave  bus
);
  localparam int B         = AXI_DATA_W / 8;
  localparam int LOG_B     = $clog2(B);
  localparam int OFF_W     = (LOG_B > 0) ? LOG_B : 1;
  localparam int CW        = (TRANSFER_LEN_W > 14) ? TRANSFER_LEN_W : 14;
  localparam int MAX_BYTES = MAX_BEATS * B;
  localparam logic [13:0] CAP = (MAX_BYTES > 4096) ? 14'd4096 : 14'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t                    state, state_nxt;
  logic [AXI_ADDR_W-1:0]     a;
  logic [TRANSFER_LEN_W-1:0] r;
  logic                      first;

  logic [13:0] off, base, lim, room, bytes, span;
  logic [7:0]  len;
  logic        last;

  always_comb begin
    off   = 14'(a[11:0] & 12'(B - 1));
    base  = 14'(a[11:0]) - off;
    lim   = 14'd4096 - base;
    if (lim > CAP)
      lim = CAP;
    // lim is at least one beat and off < B, so room is never zero
    room  = lim - off;
    bytes = (CW'(r) < CW'(room)) ? 14'(r) : room;
    span  = off + bytes + 14'(B - 1);
    len   = 8'((span >> LOG_B) - 14'd1);
    last  = (CW'(bytes) == CW'(r));
  end

  always_comb begin
    state_nxt          = state;
    bus.cmd_ready_o    = 1'b0;
    bus.burst_valid_o  = 1'b0;
    bus.burst_addr_o   = '0;
    bus.burst_len_o    = '0;
    bus.burst_size_o   = '0;
    bus.burst_offset_o = '0;
    bus.burst_bytes_o  = '0;
    bus.burst_first_o  = 1'b0;
    bus.burst_last_o   = 1'b0;
    bus.busy_o         = 1'b0;
    bus.done_o         = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready_o = 1'b1;
        if (bus.cmd_valid_i)
          state_nxt = (bus.cmd_len_i == '0) ? DONE : EMIT;
      end
      EMIT: begin
        bus.burst_valid_o  = 1'b1;
        bus.busy_o         = 1'b1;
        bus.burst_addr_o   = a;
        bus.burst_len_o    = len;
        bus.burst_size_o   = 3'(LOG_B);
        bus.burst_offset_o = OFF_W'(off);
        bus.burst_bytes_o  = 13'(bytes);
        bus.burst_first_o  = first;
        bus.burst_last_o   = last;
        if (bus.burst_ready_i && last)
          state_nxt = DONE;
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      r     <= '0;
      first <= 1'b0;
    end else if (state == IDLE && bus.cmd_valid_i) begin
      a     <= bus.cmd_addr_i;
      r     <= bus.cmd_len_i;
      first <= 1'b1;
    end else if (state == EMIT && bus.burst_ready_i) begin
      a     <= a + AXI_ADDR_W'(bytes);
      r     <= r - TRANSFER_LEN_W'(bytes);
      first <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_burst_splitter.sv
// tb/tb_axi_burst_splitter.sv - table-driven scoreboard bench for axi_burst_splitter (B=4, MAX_BEATS=256)
module tb_axi_burst_splitter;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [12:0] bytes;
    logic [1:0]  off;
    logic        first;
    logic        last;
  } burst_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [19:0]      len;
    int               n;
    burst_t [2:0]     b;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  burst_t sbq[$];
  req_t   vec[8];

  always #5 clk = ~clk;

  axi_burst_splitter_if #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .TRANSFER_LEN_W(20)) bus ();

  axi_burst_splitter #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .TRANSFER_LEN_W(20), .MAX_BEATS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic burst_t mk(input logic [31:0] addr, input logic [7:0] len, input logic [12:0] bytes,
                                input logic [1:0] off, input logic first, input logic last);
    burst_t x;
    x.addr = addr; x.len = len; x.bytes = bytes; x.off = off; x.first = first; x.last = last;
    return x;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] snap();
    return {bus.burst_addr_o, bus.burst_len_o, bus.burst_size_o, bus.burst_offset_o,
            bus.burst_bytes_o, bus.burst_first_o, bus.burst_last_o, bus.burst_valid_o};
  endfunction

  task automatic run_req(input req_t rq, input bit rand_ready, input int stall);
    int     cyc;
    burst_t e;
    logic [63:0] s;
    @(posedge clk); #1;
    check("cmd_ready_idle", bus.cmd_ready_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = rq.addr;
    bus.cmd_len_i   = rq.len;
    for (int k = 0; k < rq.n; k++) sbq.push_back(rq.b[k]);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_len_i   = '0;
    if (stall > 0 && sbq.size() != 0) begin
      bus.burst_ready_i = 1'b0;
      s = snap();
      check("stall_valid", bus.burst_valid_o, 1);
      repeat (stall) begin
        @(posedge clk); #1;
        check("stall_hold", snap(), s);
      end
    end
    cyc = 0;
    while (sbq.size() != 0 && cyc < 2000) begin
      bus.burst_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rand_ready || cyc == 0) check("b2b_valid", bus.burst_valid_o, 1);
      if (bus.burst_valid_o) check("busy", bus.busy_o, 1);
      if (bus.burst_valid_o && bus.burst_ready_i) begin
        e = sbq.pop_front();
        check("burst_addr", bus.burst_addr_o, e.addr);
        check("burst_len", bus.burst_len_o, e.len);
        check("burst_size", bus.burst_size_o, 3'd2);
        check("burst_bytes", bus.burst_bytes_o, e.bytes);
        check("burst_offset", bus.burst_offset_o, e.off);
        check("burst_first_last", {bus.burst_first_o, bus.burst_last_o}, {e.first, e.last});
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.burst_ready_i = 1'b0;
    if (sbq.size() != 0) begin
      check("burst_timeout", sbq.size(), 0);
      sbq.delete();
    end
    check("done_pulse", {bus.done_o, bus.busy_o, bus.burst_valid_o, bus.cmd_ready_o}, 4'b1000);
    @(posedge clk); #1;
    check("done_clear", {bus.done_o, bus.cmd_ready_o}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0; bus.burst_ready_i = 1'b0;

    vec[0] = '{addr: 32'h1000, len: 20'd16,   n: 1, b: '{burst_t'(0), burst_t'(0), mk(32'h1000, 8'd3, 13'd16, 2'd0, 1, 1)}};
    vec[1] = '{addr: 32'h0FF8, len: 20'd16,   n: 2, b: '{burst_t'(0), mk(32'h1000, 8'd1, 13'd8, 2'd0, 0, 1), mk(32'h0FF8, 8'd1, 13'd8, 2'd0, 1, 0)}};
    vec[2] = '{addr: 32'h2002, len: 20'd8,    n: 1, b: '{burst_t'(0), burst_t'(0), mk(32'h2002, 8'd2, 13'd8, 2'd2, 1, 1)}};
    vec[3] = '{addr: 32'h0000, len: 20'd3000, n: 3, b: '{mk(32'h0800, 8'd237, 13'd952, 2'd0, 0, 1),
                                                     mk(32'h0400, 8'd255, 13'd1024, 2'd0, 0, 0),
                                                     mk(32'h0000, 8'd255, 13'd1024, 2'd0, 1, 0)}};
    vec[4] = '{addr: 32'h0500, len: 20'd0,    n: 0, b: '0};
    vec[5] = '{addr: 32'h0FFE, len: 20'd10,   n: 2, b: '{burst_t'(0), mk(32'h1000, 8'd1, 13'd8, 2'd0, 0, 1), mk(32'h0FFE, 8'd0, 13'd2, 2'd2, 1, 0)}};
    vec[6] = '{addr: 32'h3001, len: 20'd1,    n: 1, b: '{burst_t'(0), burst_t'(0), mk(32'h3001, 8'd0, 13'd1, 2'd1, 1, 1)}};
    vec[7] = '{addr: 32'h0C03, len: 20'd1100, n: 2, b: '{burst_t'(0), mk(32'h1000, 8'd19, 13'd79, 2'd0, 0, 1), mk(32'h0C03, 8'd255, 13'd1021, 2'd3, 1, 0)}};

    #12;
    check("reset_outputs", {bus.cmd_ready_o, bus.burst_valid_o, bus.busy_o, bus.done_o}, 4'b1000);
    check("reset_fields", {bus.burst_addr_o, bus.burst_len_o, bus.burst_bytes_o, bus.burst_size_o}, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_req(vec[i], 1'b0, 0);
    for (int i = 0; i < 8; i++) run_req(vec[i], 1'b1, 0);
    run_req(vec[1], 1'b0, 5);
    run_req(vec[7], 1'b1, 5);

    // abort a long request after its first burst has been taken
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 32'h0; bus.cmd_len_i = 20'd3000; bus.burst_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    check("abort_first_valid", bus.burst_valid_o, 1);
    @(posedge clk); #1;
    check("abort_second_addr", {bus.burst_valid_o, bus.burst_addr_o}, {1'b1, 32'h400});
    rst_n = 1'b0;
    #1;
    check("abort_reset_outputs", {bus.cmd_ready_o, bus.burst_valid_o, bus.busy_o, bus.done_o}, 4'b1000);
    check("abort_reset_fields", {bus.burst_addr_o, bus.burst_bytes_o}, 0);
    bus.burst_ready_i = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_reset_quiet", {bus.cmd_ready_o, bus.burst_valid_o, bus.done_o}, 3'b100);
    end
    run_req(vec[0], 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
